// File: rtl/aes_uart_sched.sv
// Round-robin scheduler sharing one AES-256 engine between the encrypt (EPR) and
// decrypt (UART RX) block streams, with start/done sequencing and a watchdog.
module aes_uart_sched #(
    parameter int unsigned BLK_W   = 128,
    parameter int unsigned KEY_W   = 256,
    parameter int unsigned TMO_CYC = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_ee,
    input  logic             i_de,
    input  logic [KEY_W-1:0] i_ekey,
    input  logic [KEY_W-1:0] i_dkey,
    input  logic [BLK_W-1:0] s_enc_tdata,
    input  logic             s_enc_tvalid,
    output logic             s_enc_tready,
    input  logic [BLK_W-1:0] s_dec_tdata,
    input  logic             s_dec_tvalid,
    output logic             s_dec_tready,
    output logic [BLK_W-1:0] m_enc_tdata,
    output logic             m_enc_tvalid,
    input  logic             m_enc_tready,
    output logic [BLK_W-1:0] m_dec_tdata,
    output logic             m_dec_tvalid,
    input  logic             m_dec_tready,
    output logic             o_aes_start,
    output logic             o_aes_mode,
    output logic [KEY_W-1:0] o_aes_key,
    output logic [BLK_W-1:0] o_aes_din,
    input  logic             i_aes_done,
    input  logic [BLK_W-1:0] i_aes_dout,
    output logic             o_busy,
    output logic             o_owner,
    output logic             o_tmo,
    output logic [CNT_W-1:0] o_enc_cnt,
    output logic [CNT_W-1:0] o_dec_cnt
);

    localparam int unsigned WD_W = $clog2(TMO_CYC);

    typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_t;

    state_t          state, state_nx;
    logic [WD_W-1:0] wd;
    logic [BLK_W-1:0] res;
    logic            req_e, req_d, gnt_d, take, wd_hit, out_hs;

    always_comb begin
        req_e        = i_en & i_ee & s_enc_tvalid;
        req_d        = i_en & i_de & s_dec_tvalid;
        // On a tie the path that did not own the engine last time wins.
        gnt_d        = req_d & (~req_e | ~o_owner);
        // Readies are masked by reset so nothing is offered while rst is low.
        s_enc_tready = rst & (state == IDLE) & req_e & ~gnt_d;
        s_dec_tready = rst & (state == IDLE) & gnt_d;
        take         = s_enc_tready | s_dec_tready;
        wd_hit       = (wd == WD_W'(TMO_CYC - 1));
        out_hs       = (m_enc_tvalid & m_enc_tready) | (m_dec_tvalid & m_dec_tready);
        o_aes_start  = (state == START);
        o_tmo        = (state == RUN) & ~i_aes_done & wd_hit;
        o_busy       = (state != IDLE);
        m_enc_tdata  = res;
        m_dec_tdata  = res;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = START;
            START:   state_nx = RUN;
            RUN:     if (i_aes_done) state_nx = OUT;
                     else if (wd_hit) state_nx = IDLE;
            OUT:     if (out_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wd           <= '0;
            o_owner      <= 1'b1;
            o_aes_mode   <= 1'b0;
            o_aes_key    <= '0;
            o_aes_din    <= '0;
            res          <= '0;
            m_enc_tvalid <= 1'b0;
            m_dec_tvalid <= 1'b0;
            o_enc_cnt    <= '0;
            o_dec_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == START)
                wd <= '0;
            else if (state == RUN)
                wd <= wd + 1'b1;
            if (take) begin
                o_owner    <= gnt_d;
                o_aes_mode <= gnt_d;
                o_aes_key  <= gnt_d ? i_dkey : i_ekey;
                o_aes_din  <= gnt_d ? s_dec_tdata : s_enc_tdata;
            end
            if (state == RUN && i_aes_done) begin
                res          <= i_aes_dout;
                m_enc_tvalid <= ~o_aes_mode;
                m_dec_tvalid <= o_aes_mode;
            end
            if (out_hs) begin
                m_enc_tvalid <= 1'b0;
                m_dec_tvalid <= 1'b0;
            end
            if (m_enc_tvalid && m_enc_tready)
                o_enc_cnt <= o_enc_cnt + 1'b1;
            if (m_dec_tvalid && m_dec_tready)
                o_dec_cnt <= o_dec_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_uart_sched.sv
// Directed bench for aes_uart_sched: a latency-programmable AES stub answers start
// pulses; each task drives one scenario and checks against hand-computed values.
module tb_aes_uart_sched;

    localparam logic [127:0] PT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] CT = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    localparam logic [255:0] EK = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [255:0] DK = 256'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF_B0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [255:0] KB = 256'h55555555_66666666_77777777_88888888_99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    logic         clk = 1'b0, rst = 1'b0;
    logic         en = 1'b0, ee = 1'b0, de = 1'b0;
    logic [255:0] ekey = '0, dkey = '0;
    logic [127:0] s_enc_tdata = '0, s_dec_tdata = '0;
    logic         s_enc_tvalid = 1'b0, s_dec_tvalid = 1'b0;
    logic         s_enc_tready, s_dec_tready;
    logic [127:0] m_enc_tdata, m_dec_tdata;
    logic         m_enc_tvalid, m_dec_tvalid;
    logic         m_enc_tready = 1'b1, m_dec_tready = 1'b1;
    logic         o_aes_start, o_aes_mode, o_busy, o_owner, o_tmo;
    logic [255:0] o_aes_key;
    logic [127:0] o_aes_din;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = '0;
    logic [15:0]  o_enc_cnt, o_dec_cnt;

    logic         w_s_enc_tready, w_s_dec_tready, w_m_enc_tvalid, w_m_dec_tvalid;
    logic [127:0] w_m_enc_tdata, w_m_dec_tdata, w_aes_din;
    logic         w_aes_start, w_aes_mode, w_busy, w_owner, w_tmo;
    logic [255:0] w_aes_key;
    logic [3:0]   w_enc_cnt, w_dec_cnt;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int aes_lat = 0, mcnt = 0;
    logic [127:0] mres = '0;

    aes_uart_sched #(.BLK_W(128), .KEY_W(256), .TMO_CYC(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_ee(ee), .i_de(de), .i_ekey(ekey), .i_dkey(dkey),
        .s_enc_tdata(s_enc_tdata), .s_enc_tvalid(s_enc_tvalid), .s_enc_tready(s_enc_tready),
        .s_dec_tdata(s_dec_tdata), .s_dec_tvalid(s_dec_tvalid), .s_dec_tready(s_dec_tready),
        .m_enc_tdata(m_enc_tdata), .m_enc_tvalid(m_enc_tvalid), .m_enc_tready(m_enc_tready),
        .m_dec_tdata(m_dec_tdata), .m_dec_tvalid(m_dec_tvalid), .m_dec_tready(m_dec_tready),
        .o_aes_start(o_aes_start), .o_aes_mode(o_aes_mode), .o_aes_key(o_aes_key),
        .o_aes_din(o_aes_din), .i_aes_done(aes_done), .i_aes_dout(aes_dout),
        .o_busy(o_busy), .o_owner(o_owner), .o_tmo(o_tmo),
        .o_enc_cnt(o_enc_cnt), .o_dec_cnt(o_dec_cnt));

    // Narrow-counter twin fed the same inputs, used to reach the counter wrap quickly.
    aes_uart_sched #(.BLK_W(128), .KEY_W(256), .TMO_CYC(16), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .i_en(en), .i_ee(ee), .i_de(de), .i_ekey(ekey), .i_dkey(dkey),
        .s_enc_tdata(s_enc_tdata), .s_enc_tvalid(s_enc_tvalid), .s_enc_tready(w_s_enc_tready),
        .s_dec_tdata(s_dec_tdata), .s_dec_tvalid(s_dec_tvalid), .s_dec_tready(w_s_dec_tready),
        .m_enc_tdata(w_m_enc_tdata), .m_enc_tvalid(w_m_enc_tvalid), .m_enc_tready(m_enc_tready),
        .m_dec_tdata(w_m_dec_tdata), .m_dec_tvalid(w_m_dec_tvalid), .m_dec_tready(m_dec_tready),
        .o_aes_start(w_aes_start), .o_aes_mode(w_aes_mode), .o_aes_key(w_aes_key),
        .o_aes_din(w_aes_din), .i_aes_done(aes_done), .i_aes_dout(aes_dout),
        .o_busy(w_busy), .o_owner(w_owner), .o_tmo(w_tmo),
        .o_enc_cnt(w_enc_cnt), .o_dec_cnt(w_dec_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] aes_stub(input logic [127:0] d, input logic [255:0] k, input logic m);
        if (d == PT && !m) return CT;
        return d ^ k[127:0] ^ k[255:128] ^ {128{m}};
    endfunction

    // AES stub: done pulses aes_lat cycles after the start cycle; aes_lat=0 never answers.
    always @(negedge clk) begin
        aes_done = 1'b0;
        if (o_aes_start && aes_lat > 0) begin
            mcnt = aes_lat;
            mres = aes_stub(o_aes_din, o_aes_key, o_aes_mode);
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                aes_done = 1'b1;
                aes_dout = mres;
            end
        end
    end

    task automatic nclk;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_in(output int who, output bit ok);
        who = -1;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (s_enc_tvalid && s_enc_tready) begin who = 0; ok = 1'b1; break; end
            if (s_dec_tvalid && s_dec_tready) begin who = 1; ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_out(input bit dec, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (dec ? m_dec_tvalid : m_enc_tvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        nclk();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        en = 1'b1; ee = 1'b1; de = 1'b1; s_enc_tvalid = 1'b1; s_dec_tvalid = 1'b1;
        nclk(); nclk();
        n_checks++; if ({s_enc_tready, s_dec_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_tready: got %b want 00", {s_enc_tready, s_dec_tready}); end
        n_checks++; if ({m_enc_tvalid, m_dec_tvalid, o_aes_start, o_busy, o_tmo} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", {m_enc_tvalid, m_dec_tvalid, o_aes_start, o_busy, o_tmo}); end
        n_checks++; if (o_owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b want 1", o_owner); end
        n_checks++; if ({o_enc_cnt, o_dec_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {o_enc_cnt, o_dec_cnt}); end
        n_checks++; if ({o_aes_key, o_aes_din, m_enc_tdata, o_aes_mode} !== '0) begin n_fail++; $display("FAIL reset_data: got key %h din %h tdata %h", o_aes_key, o_aes_din, m_enc_tdata); end
        s_enc_tvalid = 1'b0; s_dec_tvalid = 1'b0; en = 1'b0; ee = 1'b0; de = 1'b0;
        rst = 1'b1;
        nclk();
    endtask

    task automatic test_encrypt;
        int who, c0; bit ok;
        en = 1'b1; ee = 1'b1; de = 1'b0; ekey = EK; dkey = DK; aes_lat = 14; m_enc_tready = 1'b1;
        s_enc_tdata = PT; s_enc_tvalid = 1'b1;
        wait_in(who, ok); c0 = cyc;
        n_checks++; if (!ok || who != 0) begin n_fail++; $display("FAIL enc_accept: got who=%0d ok=%0d want 0", who, ok); end
        @(posedge clk); #1; s_enc_tvalid = 1'b0;
        nclk();
        n_checks++; if (o_aes_start !== 1'b1 || cyc != c0 + 1) begin n_fail++; $display("FAIL enc_start: got start=%b at +%0d want 1 at +1", o_aes_start, cyc - c0); end
        n_checks++; if (o_aes_mode !== 1'b0 || o_aes_key !== EK || o_aes_din !== PT) begin n_fail++; $display("FAIL enc_operands: got mode %b key %h din %h", o_aes_mode, o_aes_key, o_aes_din); end
        nclk();
        n_checks++; if (o_aes_start !== 1'b0) begin n_fail++; $display("FAIL enc_start_pulse: got %b want 0", o_aes_start); end
        wait_out(1'b0, ok);
        n_checks++; if (!ok || cyc - c0 != 16) begin n_fail++; $display("FAIL enc_latency: got %0d want 16", cyc - c0); end
        n_checks++; if (m_enc_tdata !== CT) begin n_fail++; $display("FAIL enc_data: got %h want %h", m_enc_tdata, CT); end
        nclk();
        n_checks++; if (m_enc_tvalid !== 1'b0 || o_enc_cnt !== 16'd1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL enc_done: got valid %b cnt %0d busy %b want 0 1 0", m_enc_tvalid, o_enc_cnt, o_busy); end
    endtask

    task automatic test_round_robin;
        int who; bit ok; logic [127:0] din; logic [127:0] exp;
        int ne = 0, nd = 0;
        do_reset();
        en = 1'b1; ee = 1'b1; de = 1'b1; ekey = EK; dkey = DK; aes_lat = 3;
        m_enc_tready = 1'b1; m_dec_tready = 1'b1;
        s_enc_tdata = 128'hE000; s_dec_tdata = 128'hD000;
        s_enc_tvalid = 1'b1; s_dec_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_in(who, ok);
            din = (who == 1) ? s_dec_tdata : s_enc_tdata;
            n_checks++; if (!ok || who != (i % 2)) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", i, who, i % 2); end
            @(posedge clk); #1;
            if (who == 1) begin nd++; s_dec_tdata = 128'hD000 + 128'(nd); end
            else begin ne++; s_enc_tdata = 128'hE000 + 128'(ne); end
            if (i == 7) begin s_enc_tvalid = 1'b0; s_dec_tvalid = 1'b0; end
            exp = (who == 1) ? aes_stub(din, DK, 1'b1) : aes_stub(din, EK, 1'b0);
            wait_out(who == 1, ok);
            n_checks++; if (!ok || ((who == 1) ? m_dec_tdata : m_enc_tdata) !== exp) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", i, (who == 1) ? m_dec_tdata : m_enc_tdata, exp); end
        end
        nclk();
        n_checks++; if (o_enc_cnt !== 16'd4 || o_dec_cnt !== 16'd4) begin n_fail++; $display("FAIL rr_counts: got %0d/%0d want 4/4", o_enc_cnt, o_dec_cnt); end
    endtask

    task automatic test_backpressure;
        int who; bit ok; int bad = 0;
        logic [127:0] exp = aes_stub(128'hDB, DK, 1'b1);
        aes_lat = 2; m_dec_tready = 1'b0;
        s_dec_tdata = 128'hDB; s_dec_tvalid = 1'b1;
        wait_in(who, ok);
        n_checks++; if (!ok || who != 1) begin n_fail++; $display("FAIL bp_accept: got %0d want 1", who); end
        @(posedge clk); #1;
        s_dec_tvalid = 1'b0; s_enc_tdata = 128'hEB; s_enc_tvalid = 1'b1;
        wait_out(1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_valid: got no m_dec_tvalid want 1"); end
        for (int k = 0; k < 20; k++) begin
            if (m_dec_tvalid !== 1'b1 || m_dec_tdata !== exp || s_enc_tready !== 1'b0 || s_dec_tready !== 1'b0) bad++;
            nclk();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        m_dec_tready = 1'b1;
        nclk();
        n_checks++; if (m_dec_tvalid !== 1'b0 || o_dec_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_release: got valid %b cnt %0d want 0 5", m_dec_tvalid, o_dec_cnt); end
        n_checks++; if (s_enc_tready !== 1'b1) begin n_fail++; $display("FAIL bp_next_grant: got %b want 1", s_enc_tready); end
        s_enc_tvalid = 1'b0;
        nclk();
    endtask

    task automatic test_timeout;
        int who; bit ok; int pulses = 0, first = -1; bit leak = 1'b0;
        aes_lat = 0;
        s_enc_tdata = 128'hEC; s_enc_tvalid = 1'b1;
        wait_in(who, ok);
        n_checks++; if (!ok || who != 0) begin n_fail++; $display("FAIL tmo_accept: got %0d want 0", who); end
        @(posedge clk); #1; s_enc_tvalid = 1'b0;
        nclk();
        for (int k = 1; k <= 30; k++) begin
            nclk();
            if (o_tmo === 1'b1) begin pulses++; if (first < 0) first = k; end
            if (m_enc_tvalid || m_dec_tvalid) leak = 1'b1;
        end
        n_checks++; if (pulses != 1 || first != 16) begin n_fail++; $display("FAIL tmo_pulse: got %0d pulses at +%0d want 1 at +16", pulses, first); end
        n_checks++; if (leak || o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got leak %b busy %b want 0 0", leak, o_busy); end
        n_checks++; if (o_enc_cnt !== 16'd4 || o_dec_cnt !== 16'd5) begin n_fail++; $display("FAIL tmo_counts: got %0d/%0d want 4/5", o_enc_cnt, o_dec_cnt); end
    endtask

    task automatic test_midop;
        int who; bit ok; int seen = 0;
        aes_lat = 6; ekey = EK; en = 1'b1;
        s_enc_tdata = 128'h1234; s_enc_tvalid = 1'b1;
        wait_in(who, ok);
        @(posedge clk); #1;
        ekey = KB; en = 1'b0; s_enc_tdata = 128'h5678;
        wait_out(1'b0, ok);
        n_checks++; if (!ok || m_enc_tdata !== aes_stub(128'h1234, EK, 1'b0)) begin n_fail++; $display("FAIL mid_oldkey: got %h want %h", m_enc_tdata, aes_stub(128'h1234, EK, 1'b0)); end
        for (int k = 0; k < 5; k++) begin
            nclk();
            if (s_enc_tready !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_blocked: got %0d grant cycles want 0", seen); end
        en = 1'b1; #1;
        n_checks++; if (s_enc_tready !== 1'b1) begin n_fail++; $display("FAIL mid_regrant: got %b want 1", s_enc_tready); end
        wait_in(who, ok);
        @(posedge clk); #1; s_enc_tvalid = 1'b0;
        nclk();
        n_checks++; if (o_aes_key !== KB || o_aes_din !== 128'h5678) begin n_fail++; $display("FAIL mid_newkey: got key %h din %h", o_aes_key, o_aes_din); end
        wait_out(1'b0, ok);
        n_checks++; if (!ok || m_enc_tdata !== aes_stub(128'h5678, KB, 1'b0)) begin n_fail++; $display("FAIL mid_newdata: got %h want %h", m_enc_tdata, aes_stub(128'h5678, KB, 1'b0)); end
        nclk();
        n_checks++; if (o_enc_cnt !== 16'd6) begin n_fail++; $display("FAIL mid_count: got %0d want 6", o_enc_cnt); end
    endtask

    task automatic test_reset_in_run;
        int who; bit ok; bit leak = 1'b0;
        aes_lat = 8;
        s_enc_tdata = 128'hAB; s_enc_tvalid = 1'b1;
        wait_in(who, ok);
        @(posedge clk); #1; s_enc_tvalid = 1'b0;
        nclk(); nclk(); nclk();
        s_enc_tvalid = 1'b1; rst = 1'b0; #1;
        n_checks++; if ({o_busy, o_aes_start, s_enc_tready, m_enc_tvalid, m_dec_tvalid} !== 5'b0) begin n_fail++; $display("FAIL rrun_ctl: got %b want 00000", {o_busy, o_aes_start, s_enc_tready, m_enc_tvalid, m_dec_tvalid}); end
        n_checks++; if (o_aes_din !== '0 || o_aes_key !== '0 || o_owner !== 1'b1) begin n_fail++; $display("FAIL rrun_regs: got din %h key %h owner %b", o_aes_din, o_aes_key, o_owner); end
        n_checks++; if (o_enc_cnt !== 16'd0 || o_dec_cnt !== 16'd0) begin n_fail++; $display("FAIL rrun_cnt: got %0d/%0d want 0/0", o_enc_cnt, o_dec_cnt); end
        nclk();
        s_enc_tvalid = 1'b0; rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            nclk();
            if (m_enc_tvalid || m_dec_tvalid || o_busy) leak = 1'b1;
        end
        n_checks++; if (leak) begin n_fail++; $display("FAIL rrun_late_done: got output after reset want none"); end
    endtask

    task automatic test_back_to_back;
        int who, c_out; bit ok; logic [127:0] din;
        aes_lat = 1; en = 1'b1; ee = 1'b1; de = 1'b0; ekey = EK;
        s_enc_tdata = 128'h100; s_enc_tvalid = 1'b1;
        c_out = 0;
        for (int i = 0; i < 16; i++) begin
            wait_in(who, ok);
            din = s_enc_tdata;
            if (i > 0) begin
                n_checks++; if (!ok || cyc - c_out != 1) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 1", i, cyc - c_out); end
            end
            if (i == 15) begin
                n_checks++; if (w_enc_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d want 15", w_enc_cnt); end
            end
            @(posedge clk); #1;
            s_enc_tdata = 128'h100 + 128'(i + 1);
            if (i == 15) s_enc_tvalid = 1'b0;
            wait_out(1'b0, ok);
            c_out = cyc;
            n_checks++; if (!ok || m_enc_tdata !== aes_stub(din, EK, 1'b0)) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, m_enc_tdata, aes_stub(din, EK, 1'b0)); end
        end
        nclk();
        n_checks++; if (w_enc_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", w_enc_cnt); end
        n_checks++; if (o_enc_cnt !== 16'd16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", o_enc_cnt); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_midop();
        test_reset_in_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
